// File: rtl/scroll_pkg.sv
// Shared constants, state encoding and ring/position helpers for the HELLO scroll controller.
package scroll_pkg;

  localparam int unsigned NUM_POS = 10;
  localparam int unsigned POS_W   = 4;

  localparam logic [NUM_POS-1:0] HOT_RESET = 10'b0000000001;

  typedef logic [1:0] state_t;

  localparam state_t BLANK = 2'd0;
  localparam state_t RUN   = 2'd1;
  localparam state_t HOLD  = 2'd2;

  // Forward rotates left (bit9 wraps to bit0); reverse rotates right (bit0 wraps to bit9).
  function automatic logic [NUM_POS-1:0] ring_rotate(input logic [NUM_POS-1:0] ring,
                                                     input logic              rev);
    if (rev) ring_rotate = {ring[0], ring[NUM_POS-1:1]};
    else     ring_rotate = {ring[NUM_POS-2:0], ring[NUM_POS-1]};
  endfunction

  function automatic logic [POS_W-1:0] pos_step(input logic [POS_W-1:0] pos,
                                                input logic             rev);
    if (rev) pos_step = (pos == '0) ? POS_W'(NUM_POS - 1) : pos - POS_W'(1);
    else     pos_step = (pos == POS_W'(NUM_POS - 1)) ? '0 : pos + POS_W'(1);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser followed by a stable-count filter for the step key.
// Only instantiated when SCROLL_DEBOUNCE_EN is defined.
module key_debounce
  #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
  )
  (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
  );

  localparam int unsigned DB_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]      sync;
  logic [DB_W-1:0] stable_cnt;

  // The output only follows the synchronised level once it has differed for
  // DEBOUNCE_CYCLES consecutive samples; any agreeing sample restarts the count.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync       <= '0;
      stable_cnt <= '0;
      dout       <= 1'b0;
    end else begin
      sync <= {sync[0], din};
      if (sync[1] == dout) begin
        stable_cnt <= '0;
      end else if (stable_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_cnt <= '0;
        dout       <= sync[1];
      end else begin
        stable_cnt <= stable_cnt + DB_W'(1);
      end
    end
  end

endmodule

// File: rtl/hello_scroll_ctrl.sv
// Position driver for the eight-digit HELLO display: prescaled auto-scroll, pause, step, direction, blank.
// Define SCROLL_DEBOUNCE_EN to pass step_key through the key_debounce synchroniser/filter.
module hello_scroll_ctrl
  import scroll_pkg::*;
  #(
    parameter int unsigned TICK_DIV = 50_000_000
`ifdef SCROLL_DEBOUNCE_EN
    , parameter int unsigned DEBOUNCE_CYCLES = 500_000
`endif
  )
  (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               dir,
    input  logic               step_key,
    input  logic               blank,
    output logic [NUM_POS-1:0] hot,
    output logic [POS_W-1:0]   pos,
    output logic               tick
  );

  localparam int unsigned CNT_W = $clog2(TICK_DIV);

  state_t             state;
  state_t             nxt_state;
  logic [CNT_W-1:0]   presc;
  logic [NUM_POS-1:0] ring;
  logic [NUM_POS-1:0] ring_nxt;
  logic [POS_W-1:0]   pos_nxt;
  logic               key_s;
  logic               key_prev;
  logic               wrap;
  logic               step_go;
  logic               advance;

`ifdef SCROLL_DEBOUNCE_EN
  key_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_key_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (step_key),
    .dout  (key_s)
  );
`else
  assign key_s = step_key;
`endif

  // NOTE: every signal written in always_comb gets a default first so no latch is inferred.
  always_comb begin
    nxt_state = HOLD;
    if (blank)    nxt_state = BLANK;
    else if (run) nxt_state = RUN;
  end

  // Wrap and step are both qualified by the next state, so blank or a falling
  // run in the same cycle cancels the advance.
  assign wrap    = (nxt_state == RUN) && (presc == CNT_W'(TICK_DIV - 1));
  assign step_go = (state == HOLD) && (nxt_state == HOLD) && key_s && !key_prev;
  assign advance = wrap || step_go;

  assign ring_nxt = advance ? ring_rotate(ring, dir) : ring;
  assign pos_nxt  = advance ? pos_step(pos, dir)     : pos;

  // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= HOLD;
      presc    <= '0;
      ring     <= HOT_RESET;
      pos      <= '0;
      hot      <= HOT_RESET;
      tick     <= 1'b0;
      key_prev <= 1'b1;
    end else begin
      state    <= nxt_state;
      ring     <= ring_nxt;
      pos      <= pos_nxt;
      hot      <= (nxt_state == BLANK) ? '0 : ring_nxt;
      tick     <= wrap;
      key_prev <= key_s;
      if (nxt_state != RUN) presc <= '0;
      else if (wrap)        presc <= '0;
      else                  presc <= presc + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hello_scroll_ctrl.sv
// Self-checking bench for hello_scroll_ctrl (TICK_DIV=4): directed vector table plus randomized run against a model.
module tb_hello_scroll_ctrl;

  localparam int TD = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic       dir = 1'b0;
  logic       step_key = 1'b0;
  logic       blank = 1'b0;
  logic [9:0] hot;
  logic [3:0] pos;
  logic       tick;

  hello_scroll_ctrl #(.TICK_DIV(TD)) dut (
    .clk      (clk),
    .reset    (reset),
    .run      (run),
    .dir      (dir),
    .step_key (step_key),
    .blank    (blank),
    .hot      (hot),
    .pos      (pos),
    .tick     (tick)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: position index, cycles spent running since the last advance/resume.
  int m_pos = 0;
  int m_cnt = 0;
  bit m_kp = 1'b1;
  bit m_blanked = 1'b0;
  bit m_tick = 1'b0;
  bit m_prev_hold = 1'b1;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit hold_now;
    bit rise;
    if (reset) begin
      m_pos = 0; m_cnt = 0; m_kp = 1'b1; m_blanked = 1'b0;
      m_tick = 1'b0; m_prev_hold = 1'b1;
    end else begin
      hold_now = !blank && !run;
      rise     = step_key && !m_kp;
      m_tick   = 1'b0;
      if (blank) begin
        m_cnt = 0;
      end else if (run) begin
        m_cnt++;
        if (m_cnt == TD) begin
          m_cnt  = 0;
          m_tick = 1'b1;
          m_pos  = (m_pos + (dir ? 9 : 1)) % 10;
        end
      end else begin
        m_cnt = 0;
        if (m_prev_hold && rise) m_pos = (m_pos + (dir ? 9 : 1)) % 10;
      end
      m_kp        = step_key;
      m_prev_hold = hold_now;
      m_blanked   = blank;
    end
  endtask

  task automatic cycle();
    int exp_hot;
    @(posedge clk);
    model_edge();
    #1;
    exp_hot = m_blanked ? 0 : (1 << m_pos);
    check("model_hot", int'(hot), exp_hot);
    check("model_pos", int'(pos), m_pos);
    check("model_tick", int'(tick), int'(m_tick));
  endtask

  typedef struct {
    bit         rst;
    bit         run;
    bit         dir;
    bit         key;
    bit         blank;
    int         n;
    logic [9:0] hot;
    int         pos;
    bit         tick;
  } vec_t;

  vec_t vt[$];

  function automatic vec_t mk(bit r, bit rn, bit d, bit k, bit b, int n,
                              logic [9:0] h, int p, bit t);
    vec_t v;
    v.rst = r; v.run = rn; v.dir = d; v.key = k; v.blank = b;
    v.n = n; v.hot = h; v.pos = p; v.tick = t;
    return v;
  endfunction

  initial begin
    // rst run dir key blank cycles | hot pos tick
    vt.push_back(mk(0,1,0,0,0, 3, 10'h001,0,0)); // prescaler filling
    vt.push_back(mk(0,1,0,0,0, 1, 10'h002,1,1)); // 4th cycle advances
    vt.push_back(mk(0,1,0,0,0, 4, 10'h004,2,1));
    vt.push_back(mk(0,1,0,0,0,32, 10'h001,0,1)); // forward wrap 9 -> 0
    vt.push_back(mk(0,1,1,0,0, 4, 10'h200,9,1)); // reverse from 0
    vt.push_back(mk(0,1,1,0,0, 4, 10'h100,8,1));
    vt.push_back(mk(0,0,0,0,0, 1, 10'h100,8,0)); // hold
    vt.push_back(mk(0,0,0,1,0, 1, 10'h200,9,0)); // step 1
    vt.push_back(mk(0,0,0,0,0, 1, 10'h200,9,0));
    vt.push_back(mk(0,0,0,1,0, 1, 10'h001,0,0)); // step 2
    vt.push_back(mk(0,0,0,0,0, 1, 10'h001,0,0));
    vt.push_back(mk(0,0,0,1,0, 1, 10'h002,1,0)); // step 3
    vt.push_back(mk(0,0,0,0,0, 1, 10'h002,1,0));
    vt.push_back(mk(0,0,0,1,0,10, 10'h004,2,0)); // held key: one step only
    vt.push_back(mk(0,0,0,0,0, 1, 10'h004,2,0));
    vt.push_back(mk(0,1,0,0,0, 2, 10'h004,2,0));
    vt.push_back(mk(0,1,0,1,0, 1, 10'h004,2,0)); // step ignored in run
    vt.push_back(mk(0,1,0,0,0, 1, 10'h008,3,1)); // only the tick advances
    vt.push_back(mk(0,1,0,0,0, 8, 10'h020,5,1));
    vt.push_back(mk(0,1,0,0,1, 1, 10'h000,5,0)); // blank next cycle
    vt.push_back(mk(0,1,0,0,1, 6, 10'h000,5,0)); // no advances while blanked
    vt.push_back(mk(0,0,0,0,0, 1, 10'h020,5,0)); // frame restored
    vt.push_back(mk(0,1,0,0,0, 3, 10'h020,5,0));
    vt.push_back(mk(0,1,0,0,0, 1, 10'h040,6,1)); // full period after resume
    vt.push_back(mk(0,1,0,0,0, 4, 10'h080,7,1));
    vt.push_back(mk(0,1,0,0,0, 3, 10'h080,7,0)); // next edge would wrap
    vt.push_back(mk(1,1,0,1,0, 1, 10'h001,0,0)); // reset beats the wrap
    vt.push_back(mk(0,0,0,1,0, 2, 10'h001,0,0)); // key held through reset
    vt.push_back(mk(0,0,0,0,0, 1, 10'h001,0,0));
    vt.push_back(mk(0,1,0,0,0, 3, 10'h001,0,0));
    vt.push_back(mk(0,0,0,0,0, 1, 10'h001,0,0)); // run falls on wrap
    vt.push_back(mk(0,1,0,0,0, 4, 10'h002,1,1));
    vt.push_back(mk(0,1,0,0,0, 3, 10'h002,1,0));
    vt.push_back(mk(0,1,0,0,1, 1, 10'h000,1,0)); // blank on wrap
    vt.push_back(mk(0,1,0,0,0, 4, 10'h004,2,1));
    vt.push_back(mk(0,0,0,1,1, 1, 10'h000,2,0)); // key rises while blanked
    vt.push_back(mk(0,0,0,1,0, 1, 10'h004,2,0)); // not queued
    vt.push_back(mk(0,0,0,0,0, 1, 10'h004,2,0));

    reset = 1'b1;
    cycle();
    check("reset_hot", int'(hot), 'h001);
    check("reset_pos", int'(pos), 0);
    check("reset_tick", int'(tick), 0);

    for (int i = 0; i < vt.size(); i++) begin
      reset = vt[i].rst; run = vt[i].run; dir = vt[i].dir;
      step_key = vt[i].key; blank = vt[i].blank;
      for (int c = 0; c < vt[i].n; c++) cycle();
      check($sformatf("vec%0d_hot", i), int'(hot), int'(vt[i].hot));
      check($sformatf("vec%0d_pos", i), int'(pos), vt[i].pos);
      check($sformatf("vec%0d_tick", i), int'(tick), int'(vt[i].tick));
    end

    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(199) == 0);
      if ($urandom_range(15) == 0) run = ~run;
      if ($urandom_range(19) == 0) blank = ~blank;
      if ($urandom_range(9) == 0) dir = ~dir;
      if ($urandom_range(2) == 0) step_key = ~step_key;
      cycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
